// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state
// encoding and saturating arithmetic used by the loss counter.
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser bringing the raw PLL LOCKED flag into the
// supervisor clock domain; clears to "not locked" on reset.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // shift chain, oldest sample at the top
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises one PLL: pulses its reset, qualifies LOCKED, retries and
// falls back to the other clock input, and gates user event counters.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int   RST_PULSE_CYC    = 16,
  parameter int   LOCK_TIMEOUT_CYC = 65536,
  parameter int   STABLE_CYC       = 1024,
  parameter int   MAX_RETRIES      = 3,
  parameter logic CLKINSEL_INIT    = 1'b1,
  parameter int   SYNC_STAGES      = 2,
  parameter int   NUM_CNT          = 6,
  parameter int   CNT_W            = 24,
  parameter int   CNT_TAP          = 21
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_locked,
  input  logic               i_restart,
  input  logic [NUM_CNT-1:0] i_ev,
  output logic               o_pll_rst,
  output logic               o_clkinsel,
  output logic               o_locked,
  output logic               o_fail,
  output logic [2:0]         o_state,
  output logic [7:0]         o_loss_cnt,
  output logic [23:0]        o_lock_time,
  output logic [NUM_CNT-1:0] o_cnt
);

  localparam int PUL_W = $clog2(RST_PULSE_CYC + 1);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int STB_W = $clog2(STABLE_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);

  logic w_lock_s;

  state_e             r_state,      w_state_nxt;
  logic [PUL_W-1:0]   r_pulse_cnt,  w_pulse_cnt_nxt;
  logic [TMR_W-1:0]   r_timer,      w_timer_nxt;
  logic [STB_W-1:0]   r_stable_cnt, w_stable_cnt_nxt;
  logic [RTY_W-1:0]   r_retries,    w_retries_nxt;
  logic               r_switched,   w_switched_nxt;
  logic               r_clkinsel,   w_clkinsel_nxt;
  logic [7:0]         r_loss_cnt,   w_loss_cnt_nxt;
  logic [23:0]        r_lock_time,  w_lock_time_nxt;
  logic               r_pll_rst;
  logic               r_locked;
  logic               r_fail;
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];

  logic               w_timeout;
  logic [31:0]        w_lt_ext;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (w_lock_s)
  );

  assign w_timeout = (r_timer == TMR_LAST);
  // lock time is measured up to the edge where o_locked rises, hence +1
  assign w_lt_ext  = 32'(r_timer) + 32'd1;

  // next-state and datapath decisions; restart overrides everything
  always_comb begin
    w_state_nxt      = r_state;
    w_pulse_cnt_nxt  = r_pulse_cnt;
    w_timer_nxt      = r_timer;
    w_stable_cnt_nxt = r_stable_cnt;
    w_retries_nxt    = r_retries;
    w_switched_nxt   = r_switched;
    w_clkinsel_nxt   = r_clkinsel;
    w_loss_cnt_nxt   = r_loss_cnt;
    w_lock_time_nxt  = r_lock_time;
    if (i_restart) begin
      w_state_nxt     = ST_RESET_PLL;
      w_pulse_cnt_nxt = '0;
      w_retries_nxt   = '0;
      w_switched_nxt  = 1'b0;
      w_clkinsel_nxt  = CLKINSEL_INIT;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_pulse_cnt == PUL_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end else begin
            w_pulse_cnt_nxt = r_pulse_cnt + PUL_W'(1);
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          if (w_timeout) begin
            w_state_nxt     = ST_RESET_PLL;
            w_pulse_cnt_nxt = '0;
            if (32'(r_retries) + 32'd1 < 32'(MAX_RETRIES)) begin
              w_retries_nxt = r_retries + RTY_W'(1);
            end else if (!r_switched) begin
              w_clkinsel_nxt = ~r_clkinsel;
              w_switched_nxt = 1'b1;
              w_retries_nxt  = '0;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
            if (r_state == ST_WAIT_LOCK) begin
              if (w_lock_s) begin
                w_state_nxt      = ST_STABLE;
                w_stable_cnt_nxt = '0;
              end else begin
                w_state_nxt = ST_WAIT_LOCK;
              end
            end else if (!w_lock_s) begin
              w_state_nxt = ST_WAIT_LOCK;
            end else if (r_stable_cnt == STB_LAST) begin
              w_state_nxt = ST_LOCKED;
              if (w_lt_ext > 32'h00FF_FFFF) begin
                w_lock_time_nxt = 24'hFF_FFFF;
              end else begin
                w_lock_time_nxt = w_lt_ext[23:0];
              end
            end else begin
              w_stable_cnt_nxt = r_stable_cnt + STB_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!w_lock_s) begin
            w_state_nxt     = ST_RESET_PLL;
            w_pulse_cnt_nxt = '0;
            w_loss_cnt_nxt  = sat_inc8(r_loss_cnt);
            w_retries_nxt   = '0;
            w_switched_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt     = ST_RESET_PLL;
          w_pulse_cnt_nxt = '0;
        end
      endcase
    end
  end

  // state and control registers; status outputs follow the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RESET_PLL;
      r_pulse_cnt  <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
      r_retries    <= '0;
      r_switched   <= 1'b0;
      r_clkinsel   <= CLKINSEL_INIT;
      r_loss_cnt   <= 8'd0;
      r_lock_time  <= 24'd0;
      r_pll_rst    <= 1'b1;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pulse_cnt  <= w_pulse_cnt_nxt;
      r_timer      <= w_timer_nxt;
      r_stable_cnt <= w_stable_cnt_nxt;
      r_retries    <= w_retries_nxt;
      r_switched   <= w_switched_nxt;
      r_clkinsel   <= w_clkinsel_nxt;
      r_loss_cnt   <= w_loss_cnt_nxt;
      r_lock_time  <= w_lock_time_nxt;
      r_pll_rst    <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_fail       <= (w_state_nxt == ST_FAIL);
    end
  end

  // event counters run only while the qualified lock is presented to users
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (r_locked) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(i_ev[i]);
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_tap
    assign o_cnt[g] = r_cnt[g][CNT_TAP];
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_clkinsel  = r_clkinsel;
  assign o_locked    = r_locked;
  assign o_fail      = r_fail;
  assign o_state     = r_state;
  assign o_loss_cnt  = r_loss_cnt;
  assign o_lock_time = r_lock_time;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: lock sequencing, retries,
// fallback, restart, lock loss, event counters and async reset.
module tb_pll_lock_supervisor;

  localparam int CW = 10;
  localparam int CT = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked_in = 1'b0;
  logic        restart = 1'b0;
  logic [5:0]  ev = 6'd0;
  logic        pll_rst, sel, lk, fl;
  logic [2:0]  st;
  logic [7:0]  loss;
  logic [23:0] lt;
  logic [5:0]  cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0] ev;
    int         cycles;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t       vecs [5];
  logic [5:0] sb_q [$];

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (4),
    .LOCK_TIMEOUT_CYC (50),
    .STABLE_CYC       (8),
    .MAX_RETRIES      (2),
    .CLKINSEL_INIT    (1'b1),
    .SYNC_STAGES      (2),
    .NUM_CNT          (6),
    .CNT_W            (CW),
    .CNT_TAP          (CT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_locked    (locked_in),
    .i_restart   (restart),
    .i_ev        (ev),
    .o_pll_rst   (pll_rst),
    .o_clkinsel  (sel),
    .o_locked    (lk),
    .o_fail      (fl),
    .o_state     (st),
    .o_loss_cnt  (loss),
    .o_lock_time (lt),
    .o_cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // waits for the PLL reset pulse and counts its high samples
  task automatic measure_pulse(output int w);
    int guard = 0;
    while (!pll_rst && guard < 500) begin
      tick(1);
      guard++;
    end
    w = 0;
    while (pll_rst && w < 500) begin
      w++;
      tick(1);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!pll_rst && n < 500) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_locked(input int budget, output int n);
    n = 0;
    while (!lk && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, t;
    logic [5:0] exp_c;

    vecs[0] = '{ev: 6'b000011, cycles: 512, exp_cnt: 6'b000011};
    vecs[1] = '{ev: 6'b000100, cycles: 512, exp_cnt: 6'b000111};
    vecs[2] = '{ev: 6'b000001, cycles: 512, exp_cnt: 6'b000110};
    vecs[3] = '{ev: 6'b111000, cycles: 512, exp_cnt: 6'b111110};
    vecs[4] = '{ev: 6'b000010, cycles: 512, exp_cnt: 6'b111100};

    // reset values
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sel", 32'(sel), 32'd1);
    chk("rst_locked", 32'(lk), 32'd0);
    chk("rst_fail", 32'(fl), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_loss", 32'(loss), 32'd0);
    chk("rst_lock_time", 32'(lt), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;

    // A: lock arrives 10 cycles after the reset pulse ends
    measure_pulse(w);
    chk("a_pulse_w", 32'(w), 32'd4);
    tick(10);
    locked_in = 1'b1;
    t = 10;
    while (!lk && t < 100) begin
      tick(1);
      t++;
    end
    chk("a_locked", 32'(lk), 32'd1);
    chk_rng("a_lock_delay", t, 19, 21);
    chk("a_lock_time", 32'(lt), 32'(t));
    chk("a_sel", 32'(sel), 32'd1);
    chk("a_state", 32'(st), 32'd3);

    // counter table, expected tap values pushed as stimulus is applied
    for (int i = 0; i < 5; i++) begin
      ev = vecs[i].ev;
      sb_q.push_back(vecs[i].exp_cnt);
      tick(vecs[i].cycles);
      exp_c = sb_q.pop_front();
      chk($sformatf("cnt_vec%0d", i), 32'(cnt), 32'(exp_c));
    end
    ev = 6'd0;

    // B: lock drops for 3 cycles
    locked_in = 1'b0;
    tick(3);
    locked_in = 1'b1;
    chk("b_unlocked", 32'(lk), 32'd0);
    chk("b_loss", 32'(loss), 32'd1);
    measure_pulse(w);
    chk("b_pulse_w", 32'(w), 32'd4);
    chk("b_cnt_clr", 32'(cnt), 32'd0);
    wait_locked(100, n);
    chk("b_relock", 32'(lk), 32'd1);
    chk("b_sel", 32'(sel), 32'd1);

    // C: restart coincident with lock loss, then a glitch in STABLE
    locked_in = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("c_state_rst", 32'(st), 32'd0);
    chk("c_loss_kept", 32'(loss), 32'd1);
    measure_pulse(w);
    chk("c_pulse_w", 32'(w), 32'd4);
    locked_in = 1'b1;
    tick(5);
    locked_in = 1'b0;
    tick(1);
    locked_in = 1'b1;
    tick(6);
    chk("c_not_yet", 32'(lk), 32'd0);
    chk("c_stable", 32'(st), 32'd2);
    t = 12;
    while (!lk && t < 100) begin
      tick(1);
      t++;
    end
    chk_rng("c_lock_delay", t, 16, 18);
    chk("c_lock_time", 32'(lt), 32'(t));

    // D: never locks -> 2 attempts per input, then FAIL
    locked_in = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    for (int a = 0; a < 4; a++) begin
      measure_pulse(w);
      chk($sformatf("d_pulse_w%0d", a), 32'(w), 32'd4);
      chk($sformatf("d_sel%0d", a), 32'(sel), (a < 2) ? 32'd1 : 32'd0);
      count_low(n);
      chk($sformatf("d_wait%0d", a), 32'(n), 32'd50);
    end
    tick(20);
    chk("d_fail", 32'(fl), 32'd1);
    chk("d_state", 32'(st), 32'd4);
    chk("d_pll_rst", 32'(pll_rst), 32'd1);

    // E: restart out of FAIL
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("e_state", 32'(st), 32'd0);
    chk("e_sel", 32'(sel), 32'd1);
    chk("e_fail", 32'(fl), 32'd0);

    // F: restart in the same cycle as a timeout clears the retry count
    measure_pulse(w);
    tick(49);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    measure_pulse(w);
    chk("f_pulse_w", 32'(w), 32'd4);
    count_low(n);
    chk("f_wait0", 32'(n), 32'd50);
    measure_pulse(w);
    chk("f_sel_after_1", 32'(sel), 32'd1);
    count_low(n);
    chk("f_wait1", 32'(n), 32'd50);
    measure_pulse(w);
    chk("f_sel_switched", 32'(sel), 32'd0);
    locked_in = 1'b1;
    wait_locked(100, n);
    chk("f_locked", 32'(lk), 32'd1);
    chk("f_sel_locked", 32'(sel), 32'd0);
    chk("f_lock_time", 32'(lt), 32'(n));

    // G: count then async reset mid-count
    ev = 6'b111111;
    tick(600);
    chk("g_cnt", 32'(cnt), 32'h3F);
    rst_n = 1'b0;
    #1;
    chk("g_pll_rst", 32'(pll_rst), 32'd1);
    chk("g_sel", 32'(sel), 32'd1);
    chk("g_locked", 32'(lk), 32'd0);
    chk("g_state", 32'(st), 32'd0);
    chk("g_loss", 32'(loss), 32'd0);
    chk("g_lock_time", 32'(lt), 32'd0);
    chk("g_cnt_rst", 32'(cnt), 32'd0);
    ev = 6'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
